// File: rtl/debug_cmd_frame_ctrl.sv
// Debug command framer: hunts for a sync byte after the UART RX, parses CMD/LEN/payload/XOR checksum,
// streams payload bytes on a ready/valid write port and pulses done or err once per frame.
module debug_cmd_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         TIMEOUT_TICKS = 4096,
  parameter int         TIMEOUT_SIZE  = 13
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_enable,
  output logic [7:0] o_cmd,
  output logic       o_wr_en,
  input  logic       i_wr_ready,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    GET_CMD = 6'b000010,
    GET_LEN = 6'b000100,
    PAYLOAD = 6'b001000,
    GET_CHK = 6'b010000,
    DRAIN   = 6'b100000
  } state_t;

  state_t                  state, state_nxt;
  logic [7:0]              chk, len, idx;
  logic [TIMEOUT_SIZE-1:0] tmo_cnt;

  logic       accept, wr_stall, tmo_hit, overrun, chk_bad;
  logic [7:0] cmd_nxt, chk_nxt, len_nxt, idx_nxt, wr_addr_nxt, wr_data_nxt;
  logic       wr_en_nxt, done_nxt, err_nxt;
  logic [1:0] code_nxt;

  assign accept   = o_wr_en & i_wr_ready;
  assign wr_stall = o_wr_en & ~i_wr_ready;
  // Fires on the edge where the idle counter steps onto TIMEOUT_TICKS-1; a byte in that cycle wins.
  assign tmo_hit  = (state != IDLE) & ~i_rx_valid &
                    (tmo_cnt == TIMEOUT_SIZE'(TIMEOUT_TICKS - 2));
  assign overrun  = (state == PAYLOAD) & i_rx_valid & wr_stall;
  assign chk_bad  = (i_rx_data != chk);
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_enable || tmo_hit) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_rx_valid && i_rx_data == SYNC_BYTE) state_nxt = GET_CMD;
        GET_CMD: if (i_rx_valid) state_nxt = GET_LEN;
        GET_LEN: if (i_rx_valid) state_nxt = (i_rx_data != 8'd0) ? PAYLOAD : GET_CHK;
        PAYLOAD: begin
          if (overrun)                              state_nxt = IDLE;
          else if (i_rx_valid && idx == len - 8'd1) state_nxt = GET_CHK;
        end
        GET_CHK: if (i_rx_valid) state_nxt = (!chk_bad && wr_stall) ? DRAIN : IDLE;
        DRAIN:   if (accept) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_nxt     = o_cmd;
    chk_nxt     = chk;
    len_nxt     = len;
    idx_nxt     = idx;
    wr_addr_nxt = o_wr_addr;
    wr_data_nxt = o_wr_data;
    wr_en_nxt   = wr_stall;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    code_nxt    = o_err_code;
    if (!i_enable) begin
      wr_en_nxt = 1'b0;
    end else if (tmo_hit) begin
      wr_en_nxt = 1'b0;
      err_nxt   = 1'b1;
      code_nxt  = 2'd2;
    end else if (i_rx_valid || state == DRAIN) begin
      case (state)
        GET_CMD: begin
          cmd_nxt = i_rx_data;
          chk_nxt = i_rx_data;
        end
        GET_LEN: begin
          len_nxt = i_rx_data;
          chk_nxt = chk ^ i_rx_data;
          idx_nxt = 8'd0;
        end
        PAYLOAD: begin
          if (overrun) begin
            wr_en_nxt = 1'b0;
            err_nxt   = 1'b1;
            code_nxt  = 2'd3;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_data_nxt = i_rx_data;
            wr_addr_nxt = idx;
            chk_nxt     = chk ^ i_rx_data;
            idx_nxt     = idx + 8'd1;
          end
        end
        // A bad checksum leaves any pending write alone; the sink discards it without a done.
        GET_CHK: begin
          if (chk_bad) begin
            err_nxt  = 1'b1;
            code_nxt = 2'd1;
          end else if (!wr_stall) begin
            done_nxt = 1'b1;
          end
        end
        DRAIN:   done_nxt = accept;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      o_rx_enable  <= 1'b0;
      o_cmd        <= 8'd0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= 8'd0;
      o_wr_data    <= 8'd0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= 2'd0;
      chk          <= 8'd0;
      len          <= 8'd0;
      idx          <= 8'd0;
      tmo_cnt      <= '0;
    end else begin
      o_rx_enable  <= i_enable;
      o_cmd        <= cmd_nxt;
      o_wr_en      <= wr_en_nxt;
      o_wr_addr    <= wr_addr_nxt;
      o_wr_data    <= wr_data_nxt;
      o_frame_done <= done_nxt;
      o_frame_err  <= err_nxt;
      o_err_code   <= code_nxt;
      chk          <= chk_nxt;
      len          <= len_nxt;
      idx          <= idx_nxt;
      tmo_cnt      <= (state == IDLE || i_rx_valid) ? '0 : tmo_cnt + TIMEOUT_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_debug_cmd_frame_ctrl.sv
// Scoreboard bench for debug_cmd_frame_ctrl: directed frames push expected writes/events,
// a negedge monitor pops and compares whenever the DUT accepts a write or pulses done/err.
module tb_debug_cmd_frame_ctrl;

  logic       i_clk = 1'b0;
  logic       reset;
  logic       i_enable;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_rx_enable;
  logic [7:0] o_cmd;
  logic       o_wr_en;
  logic       i_wr_ready;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_done;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  debug_cmd_frame_ctrl #(
    .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(4096), .TIMEOUT_SIZE(13)
  ) dut (
    .i_clk(i_clk), .reset(reset), .i_enable(i_enable),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_enable(o_rx_enable), .o_cmd(o_cmd),
    .o_wr_en(o_wr_en), .i_wr_ready(i_wr_ready),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
    .o_err_code(o_err_code), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] cmd;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  wr_t mon_w;
  ev_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    wq.push_back({a, d});
  endtask

  task automatic exp_done(input logic [7:0] cmd);
    eq.push_back({1'b0, 2'd0, cmd});
  endtask

  task automatic exp_err(input logic [1:0] code);
    eq.push_back({1'b1, code, 8'd0});
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 50 && (wq.size() != 0 || eq.size() != 0); i++) begin
      @(posedge i_clk); #1;
    end
    check(name, wq.size() + eq.size(), 0);
  endtask

  // Write accepted when o_wr_en & i_wr_ready hold just before the next rising edge.
  always @(negedge i_clk) begin
    if (reset === 1'b0) begin
      if (o_wr_en && i_wr_ready) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", o_wr_addr, o_wr_data);
        end else begin
          mon_w = wq.pop_front();
          check("wr_addr", o_wr_addr, mon_w.addr);
          check("wr_data", o_wr_data, mon_w.data);
        end
      end
      if (o_frame_done || o_frame_err) begin
        check("pulse_exclusive", o_frame_done & o_frame_err, 0);
        if (eq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event: got done=%0b err=%0b expected none", o_frame_done, o_frame_err);
        end else begin
          mon_e = eq.pop_front();
          check("event_kind_err", o_frame_err, mon_e.is_err);
          if (mon_e.is_err) check("err_code", o_err_code, mon_e.code);
          else              check("done_cmd", o_cmd, mon_e.cmd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_enable = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'd0; i_wr_ready = 1'b0;
    repeat (2) @(posedge i_clk); #1;
    check("reset_outputs", {o_rx_enable, o_cmd, o_wr_en, o_wr_addr, o_wr_data,
                            o_frame_done, o_frame_err, o_err_code, o_busy}, 0);
    reset = 1'b0; i_enable = 1'b1;
    @(posedge i_clk); #1;
    check("rx_enable_on", o_rx_enable, 1);

    // Two-byte payload, sink always ready.
    i_wr_ready = 1'b1;
    exp_wr(8'h00, 8'h11); exp_wr(8'h01, 8'h22); exp_done(8'h10);
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    wait_empty("t1_drain");
    check("t1_cmd", o_cmd, 8'h10);

    // Empty payload good, then bad checksum.
    exp_done(8'h07);
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    wait_empty("t2a_drain");
    exp_err(2'd1);
    send(8'hA5); send(8'h07); send(8'h00); send(8'h00);
    wait_empty("t2b_drain");
    check("t2_code_hold", o_err_code, 2'd1);

    // Leading junk byte ignored.
    exp_wr(8'h00, 8'h44); exp_done(8'h03);
    send(8'h55); send(8'hA5); send(8'h03); send(8'h01); send(8'h44); send(8'h46);
    wait_empty("t3_drain");

    // Overrun: sink stalled while the next payload byte arrives.
    i_wr_ready = 1'b0;
    exp_err(2'd3);
    send(8'hA5); send(8'h01); send(8'h02); send(8'hAA); send(8'hBB);
    wait_empty("t4a_drain");
    check("t4_wr_en_cleared", o_wr_en, 0);
    check("t4_idle", o_busy, 0);
    check("t4_code", o_err_code, 2'd3);

    // Accept coincides with the next byte, then the checksum waits in DRAIN.
    exp_wr(8'h00, 8'hAA); exp_wr(8'h01, 8'hBB); exp_done(8'h01);
    send(8'hA5); send(8'h01); send(8'h02); send(8'hAA);
    i_wr_ready = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'hBB;
    @(posedge i_clk); #1;
    i_wr_ready = 1'b0; i_rx_valid = 1'b0;
    @(posedge i_clk); #1;
    send(8'h12);
    repeat (3) @(posedge i_clk); #1;
    check("t4_drain_busy", o_busy, 1);
    check("t4_drain_pending", o_wr_en, 1);
    i_wr_ready = 1'b1;
    wait_empty("t4b_drain");
    check("t4b_idle", o_busy, 0);

    // Inter-byte timeout.
    exp_err(2'd2);
    send(8'hA5);
    i_rx_valid = 1'b1; i_rx_data = 8'h01;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge i_clk); #1;
      if (o_frame_err) begin
        n = i;
        break;
      end
    end
    check("t5_timeout_cycles", n, 4095);
    wait_empty("t5_drain");
    check("t5_idle", o_busy, 0);

    // Enable dropped mid-payload.
    exp_wr(8'h00, 8'h11);
    send(8'hA5); send(8'h01); send(8'h03); send(8'h11);
    i_enable = 1'b0;
    @(posedge i_clk); #1;
    check("t6_disable_busy", o_busy, 0);
    check("t6_disable_rx_en", o_rx_enable, 0);
    check("t6_disable_wr_en", o_wr_en, 0);
    check("t6_code_hold", o_err_code, 2'd2);
    i_enable = 1'b1;
    repeat (2) @(posedge i_clk); #1;
    wait_empty("t6a_drain");

    // Reset mid-frame with a write pending, then a clean frame.
    i_wr_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'h01); send(8'h55);
    reset = 1'b1;
    #1;
    check("t6_reset_outputs", {o_rx_enable, o_cmd, o_wr_en, o_wr_addr, o_wr_data,
                               o_frame_done, o_frame_err, o_err_code, o_busy}, 0);
    @(posedge i_clk); #1;
    reset = 1'b0;
    i_wr_ready = 1'b1;
    exp_wr(8'h00, 8'h77); exp_done(8'h20);
    send(8'hA5); send(8'h20); send(8'h01); send(8'h77); send(8'h56);
    wait_empty("t6b_drain");
    check("t6_cmd", o_cmd, 8'h20);

    repeat (3) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_cmd_frame_ctrl.md
Name: debug_cmd_frame_ctrl

Overview:
Sequences the debug UART receiver and turns its byte stream into framed commands. It hunts for a sync byte, then parses the command, length, payload and an XOR checksum. Payload bytes go out on a ready/valid write port, and a done or error pulse is raised per frame. It sits between the debug UART RX block and the display configuration/framebuffer write logic.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_TICKS, 4096, i_clk cycles allowed between consecutive bytes of one frame (including the drain wait).
TIMEOUT_SIZE, 13, width of the inter-byte timeout counter; must hold TIMEOUT_TICKS-1.

Ports:
i_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_enable  in  1  master enable; low forces IDLE
i_rx_valid  in  1  one-cycle pulse from the UART RX: byte available
i_rx_data  in  8  received byte, valid when i_rx_valid=1
o_rx_enable  out  1  enable to the UART RX; equals i_enable (registered)
o_cmd  out  8  command byte of the current/last frame
o_wr_en  out  1  payload write request, held until accepted
i_wr_ready  in  1  sink accepts when o_wr_en & i_wr_ready
o_wr_addr  out  8  payload byte index within the frame, 0..LEN-1
o_wr_data  out  8  payload byte
o_frame_done  out  1  one-cycle pulse: frame complete, checksum good
o_frame_err  out  1  one-cycle pulse: frame aborted
o_err_code  out  2  1=checksum, 2=timeout, 3=overrun; holds until the next error
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; internal checksum, length and index registers 0; timeout counter 0.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes. LEN=0 is legal.
- States: IDLE, GET_CMD, GET_LEN, PAYLOAD, GET_CHK, DRAIN. One-hot encoding.
- IDLE: on i_rx_valid with data==SYNC_BYTE -> GET_CMD. Other bytes are ignored with no error.
- GET_CMD: on a byte, latch o_cmd, chk<=byte -> GET_LEN.
- GET_LEN: on a byte, latch len, chk^=byte, idx<=0 -> PAYLOAD if len!=0, else GET_CHK.
- PAYLOAD, on each byte:
  - o_wr_data<=byte, o_wr_addr<=idx, o_wr_en<=1, chk^=byte, idx++.
  - After the byte with idx==len-1 -> GET_CHK.
- Write handshake:
  - o_wr_en clears the cycle after o_wr_en & i_wr_ready.
  - Byte arrives while o_wr_en=1 and i_wr_ready=0: overrun. Pulse err, code 3, clear o_wr_en, -> IDLE.
  - Byte arrives in the same cycle as an accept: no error; the new byte loads and o_wr_en stays 1.
- GET_CHK: on a byte, compare it with chk.
  - Mismatch: err pulse, code 1, -> IDLE. A pending write is still allowed to complete.
  - Match with no write pending (or accepted this cycle): o_frame_done the next cycle -> IDLE.
  - Match with a write still pending -> DRAIN.
- DRAIN: on accept, pulse o_frame_done the next cycle -> IDLE. A byte arriving in DRAIN is ignored.
- Timeout:
  - Counter clears on every i_rx_valid and whenever in IDLE.
  - It increments in all other states.
  - Reaching TIMEOUT_TICKS-1: err pulse, code 2, clear o_wr_en, -> IDLE.
  - A byte arriving in the same cycle as the timeout wins; no timeout is raised.
- i_enable low, any state: next cycle -> IDLE, o_wr_en cleared, no err pulse, o_rx_enable=0.
- Done and err pulses are mutually exclusive and registered. Their latency is 1 cycle after the deciding event.
- Payload writes are tentative; the sink commits only on o_frame_done.
- Asserting reset mid-frame returns everything to reset values immediately.

Test Plan:
1. Send A5,10,02,11,22,CHK=21 with i_wr_ready=1 -> writes (addr0,11) and (addr1,22); o_frame_done one cycle after CHK; o_cmd=10.
2. Send A5,07,00,07 -> no writes; o_frame_done pulses; then A5,07,00,00 -> o_frame_err pulses with o_err_code=1.
3. Send 55,A5,03,01,44,46 -> leading 55 ignored; one write (addr0,44); done pulses.
4. Hold i_wr_ready=0 and send A5,01,02,AA,BB -> o_frame_err on BB with code 3, o_wr_en=0, state IDLE. Repeat with i_wr_ready pulsed in the same cycle as BB -> no error.
5. Send A5,01 then idle for 4096 cycles -> err pulse with code 2 at cycle 4095 after the last byte; o_busy=0 afterwards.
6. Drop i_enable mid-payload -> IDLE next cycle with no err, o_rx_enable=0. Assert reset mid-frame -> all outputs 0; a following valid frame passes.
